// File: rtl/lcd1602_bus_receiver.sv
// rtl/lcd1602_bus_receiver.sv - HD44780-style 8-bit bus responder with shadow DDRAM, address counter and busy emulation
// Optional CGRAM storage is enabled by defining LCD1602_RX_CGRAM_EN.
module lcd1602_bus_receiver #(
  parameter int BUSY_CYCLES       = 50,
  parameter int CLEAR_BUSY_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_enable,
  input  logic [7:0] lcd_data,
  input  logic [6:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic       busy_o,
  output logic       cmd_valid_o,
  output logic       cmd_rs_o,
  output logic [7:0] cmd_byte_o,
  output logic [6:0] addr_o,
  output logic       display_on_o,
  output logic       err_o
);
  localparam int MAX_BUSY = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int CW       = $clog2(MAX_BUSY + 1);

  logic          en_s1, en_s2, en_prev;
  logic          wr_stb;
  logic [CW-1:0] busy_cnt;
  logic          cg_sel, inc_mode;
  logic [7:0]    ddram [0:79];

  logic [6:0]    addr_nxt;
  logic          cg_sel_nxt, inc_nxt, disp_nxt, do_clear, long_busy;
  logic [6:0]    wr_lin;

  // DDRAM addresses live in two 40-byte windows; CGRAM simply wraps at 64.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic cg, input logic up);
    if (cg) begin
      if (up) return {1'b0, a[5:0] + 6'd1};
      return {1'b0, a[5:0] - 6'd1};
    end
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  function automatic logic [6:0] ddram_lin(input logic [6:0] a);
    if (a[6]) return {1'b0, a[5:0]} + 7'd40;
    return {1'b0, a[5:0]};
  endfunction

  assign wr_stb    = en_prev & ~en_s2 & ~lcd_rw;
  assign busy_o    = (busy_cnt != '0);
  assign wr_lin    = ddram_lin(addr_o);
  assign rd_data_o = (rd_addr_i < 7'd80) ? ddram[rd_addr_i] : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      en_prev <= 1'b0;
    end else begin
      en_s1   <= lcd_enable;
      en_s2   <= en_s1;
      en_prev <= en_s2;
    end
  end

  always_comb begin
    addr_nxt   = addr_o;
    cg_sel_nxt = cg_sel;
    inc_nxt    = inc_mode;
    disp_nxt   = display_on_o;
    do_clear   = 1'b0;
    long_busy  = 1'b0;
    if (lcd_rs) begin
      addr_nxt = step_addr(addr_o, cg_sel, inc_mode);
    end else if (lcd_data[7]) begin
      cg_sel_nxt = 1'b0;
      addr_nxt   = (lcd_data[5:0] > 6'h27) ? 7'h00 : lcd_data[6:0];
    end else if (lcd_data[6]) begin
      cg_sel_nxt = 1'b1;
      addr_nxt   = {1'b0, lcd_data[5:0]};
    end else if (lcd_data[5]) begin
      addr_nxt = addr_o;
    end else if (lcd_data[4]) begin
      if (!lcd_data[3]) addr_nxt = step_addr(addr_o, cg_sel, lcd_data[2]);
    end else if (lcd_data[3]) begin
      disp_nxt = lcd_data[2];
    end else if (lcd_data[2]) begin
      inc_nxt = lcd_data[1];
    end else if (lcd_data[1]) begin
      addr_nxt   = 7'h00;
      cg_sel_nxt = 1'b0;
      long_busy  = 1'b1;
    end else if (lcd_data[0]) begin
      addr_nxt   = 7'h00;
      cg_sel_nxt = 1'b0;
      inc_nxt    = 1'b1;
      do_clear   = 1'b1;
      long_busy  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt     <= '0;
      cmd_valid_o  <= 1'b0;
      cmd_rs_o     <= 1'b0;
      cmd_byte_o   <= 8'h00;
      addr_o       <= 7'h00;
      cg_sel       <= 1'b0;
      inc_mode     <= 1'b1;
      display_on_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      cmd_valid_o <= wr_stb;
      if (wr_stb) begin
        busy_cnt     <= long_busy ? CW'(CLEAR_BUSY_CYCLES) : CW'(BUSY_CYCLES);
        cmd_rs_o     <= lcd_rs;
        cmd_byte_o   <= lcd_data;
        addr_o       <= addr_nxt;
        cg_sel       <= cg_sel_nxt;
        inc_mode     <= inc_nxt;
        display_on_o <= disp_nxt;
        if (busy_o) err_o <= 1'b1;
      end else if (busy_o) begin
        busy_cnt <= busy_cnt - CW'(1);
      end
    end
  end

  // Clear rewrites every byte in the same cycle as the decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 80; i++) ddram[i] <= 8'h20;
    end else if (wr_stb) begin
      if (do_clear) begin
        for (int i = 0; i < 80; i++) ddram[i] <= 8'h20;
      end else if (lcd_rs && !cg_sel) begin
        ddram[wr_lin] <= lcd_data;
      end
    end
  end

`ifdef LCD1602_RX_CGRAM_EN
  logic [7:0] cgram [0:63];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) cgram[i] <= 8'h00;
    end else if (wr_stb && lcd_rs && cg_sel) begin
      cgram[addr_o[5:0]] <= lcd_data;
    end
  end
`else
  // Without CGRAM storage, CGRAM data writes only step the address counter.
`endif

endmodule

// File: tb/tb_lcd1602_bus_receiver.sv
// tb/tb_lcd1602_bus_receiver.sv - bench for lcd1602_bus_receiver against a linear-position display model
module tb_lcd1602_bus_receiver;
  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs, lcd_rw, lcd_enable;
  logic [7:0] lcd_data;
  logic [6:0] rd_addr_i;
  logic [7:0] rd_data_o;
  logic       busy_o, cmd_valid_o, cmd_rs_o, display_on_o, err_o;
  logic [7:0] cmd_byte_o;
  logic [6:0] addr_o;

  always #5 clk = ~clk;

  lcd1602_bus_receiver dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_enable(lcd_enable), .lcd_data(lcd_data), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .cmd_valid_o(cmd_valid_o),
    .cmd_rs_o(cmd_rs_o), .cmd_byte_o(cmd_byte_o), .addr_o(addr_o),
    .display_on_o(display_on_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: display position as a linear index 0..79, CGRAM address 0..63.
  logic [7:0] m_dd [80];
  logic [7:0] m_cg [64];
  int   m_lin = 0, m_cga = 0;
  bit   m_cg_sel = 0, m_inc = 1, m_disp = 0, m_err = 0, m_rs = 0;
  logic [7:0] m_byte = 8'h00;
  int   ncyc = 0, eff_cyc = 0, dur = 0, pulses = 0;
  bit   any_stb = 0, run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_addr();
    if (m_cg_sel) return m_cga;
    return (m_lin < 40) ? m_lin : m_lin + 24;
  endfunction

  function automatic bit busy_at(input int n);
    return any_stb && ((n - eff_cyc) <= dur);
  endfunction

  task automatic model_move(input bit up);
    if (m_cg_sel) m_cga = (m_cga + (up ? 1 : 63)) % 64;
    else          m_lin = (m_lin + (up ? 1 : 79)) % 80;
  endtask

  task automatic model_apply(input bit rs, input logic [7:0] d);
    int a;
    if (busy_at(ncyc)) m_err = 1;
    dur = 50;
    if (rs) begin
      if (m_cg_sel) m_cg[m_cga] = d;
      else          m_dd[m_lin] = d;
      model_move(m_inc);
    end else if (d >= 8'h80) begin
      a = int'(d) - 128;
      m_cg_sel = 0;
      if (a <= 39)                 m_lin = a;
      else if (a >= 64 && a <= 103) m_lin = a - 24;
      else                         m_lin = 0;
    end else if (d >= 8'h40) begin
      m_cg_sel = 1;
      m_cga    = int'(d) - 64;
    end else if (d >= 8'h20) begin
      m_cg_sel = m_cg_sel;
    end else if (d >= 8'h10) begin
      if (!d[3]) model_move(d[2]);
    end else if (d >= 8'h08) begin
      m_disp = d[2];
    end else if (d >= 8'h04) begin
      m_inc = d[1];
    end else if (d >= 8'h02) begin
      m_lin = 0; m_cg_sel = 0; dur = 2000;
    end else if (d == 8'h01) begin
      for (int i = 0; i < 80; i++) m_dd[i] = 8'h20;
      m_lin = 0; m_cg_sel = 0; m_inc = 1; dur = 2000;
    end
    m_rs    = rs;
    m_byte  = d;
    eff_cyc = ncyc;
    any_stb = 1;
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (run) begin
      if (cmd_valid_o) pulses++;
      chk("busy", busy_o, busy_at(ncyc));
      chk("cmd_valid", cmd_valid_o, any_stb && (ncyc == eff_cyc + 1));
      chk("addr", addr_o, exp_addr());
      chk("cmd_rs", cmd_rs_o, m_rs);
      chk("cmd_byte", cmd_byte_o, m_byte);
      chk("display_on", display_on_o, m_disp);
      chk("err", err_o, m_err);
    end
  end

  task automatic strobe(input bit rs, input bit rw, input logic [7:0] d, input bit wait_idle, output int blen);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_enable = 1'b1;
    repeat (3) @(negedge clk);
    lcd_enable = 1'b0;
    repeat (3) @(posedge clk);
    if (!rw) model_apply(rs, d);
    blen = 0;
    if (wait_idle) begin
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (busy_o) blen++;
        else break;
      end
      chk("idle_bound", busy_o, 0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic sweep();
    for (int i = 0; i < 80; i++) begin
      rd_addr_i = 7'(i);
      #1;
      chk("ddram", rd_data_o, m_dd[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int b;
    int p0;
    for (int i = 0; i < 80; i++) m_dd[i] = 8'h20;
    for (int i = 0; i < 64; i++) m_cg[i] = 8'h00;
    reset = 1'b1; lcd_rs = 0; lcd_rw = 0; lcd_enable = 0; lcd_data = 8'h00; rd_addr_i = 7'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_addr", addr_o, 7'h00);
    chk("rst_disp", display_on_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_byte", cmd_byte_o, 8'h00);
    chk("rst_rd0", rd_data_o, 8'h20);
    reset = 1'b0;
    @(negedge clk);
    run = 1;

    strobe(0, 0, 8'h80, 1, b);
    strobe(1, 0, 8'h48, 1, b);
    strobe(1, 0, 8'h49, 1, b);
    chk("busy_len_50", b, 50);
    chk("pulses_3", pulses, 3);
    chk("addr_02", addr_o, 7'h02);
    rd_addr_i = 7'd0; #1; chk("rd0_48", rd_data_o, 8'h48);
    rd_addr_i = 7'd1; #1; chk("rd1_49", rd_data_o, 8'h49);

    strobe(0, 0, 8'hA7, 1, b);
    strobe(1, 0, 8'h41, 1, b);
    chk("addr_40", addr_o, 7'h40);
    rd_addr_i = 7'd39; #1; chk("rd39_41", rd_data_o, 8'h41);

    strobe(0, 0, 8'h04, 1, b);
    strobe(0, 0, 8'hC0, 1, b);
    strobe(1, 0, 8'h42, 1, b);
    chk("addr_27", addr_o, 7'h27);
    rd_addr_i = 7'd40; #1; chk("rd40_42", rd_data_o, 8'h42);

    strobe(0, 0, 8'h80, 1, b);
    strobe(1, 0, 8'h43, 1, b);
    chk("dec_wrap_67", addr_o, 7'h67);
    strobe(0, 0, 8'h06, 1, b);
    strobe(0, 0, 8'hE7, 1, b);
    strobe(1, 0, 8'h44, 1, b);
    chk("inc_wrap_00", addr_o, 7'h00);
    rd_addr_i = 7'd79; #1; chk("rd79_44", rd_data_o, 8'h44);
    strobe(0, 0, 8'h85, 1, b);
    strobe(0, 0, 8'hB0, 1, b);
    chk("clamp_00", addr_o, 7'h00);
    strobe(0, 0, 8'h14, 1, b);
    chk("shift_right", addr_o, 7'h01);
    strobe(0, 0, 8'h10, 1, b);
    strobe(0, 0, 8'h18, 1, b);
    chk("shift_left_then_disp_shift", addr_o, 7'h00);
    sweep();

    strobe(0, 0, 8'h01, 1, b);
    chk("clear_busy_2000", b, 2000);
    chk("clear_addr", addr_o, 7'h00);
    for (int i = 0; i < 80; i++) begin
      rd_addr_i = 7'(i); #1;
      chk("clear_ram", rd_data_o, 8'h20);
    end

    p0 = pulses;
    strobe(0, 1, 8'h81, 1, b);
    chk("read_ignored", pulses, p0);

    strobe(0, 0, 8'h0C, 0, b);
    strobe(0, 0, 8'h00, 1, b);
    chk("disp_on", display_on_o, 1);
    chk("err_set", err_o, 1);
    chk("busy_reload_50", b, 50);

    strobe(0, 0, 8'h48, 1, b);
    strobe(1, 0, 8'h1F, 1, b);
    chk("cg_addr_09", addr_o, 7'h09);
`ifdef LCD1602_RX_CGRAM_EN
    chk("cgram8", dut.cgram[8], 8'h1F);
`endif
    chk("err_sticky", err_o, 1);
    sweep();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
